npc_mc_ctrl: RTL and testbench
==============================

Name: npc_mc_ctrl

Overview:
Parametrised multi-cycle sequencer for the NPC core. It replaces the single-cycle PC/ebreak control with an explicit FETCH -> EXEC -> WB state machine. Instruction fetch uses a valid/ready handshake, EXU completion is handshaked, and a run/pause control is provided. Halt is sticky and carries a cause (ebreak, fetch fault, fetch timeout, misaligned PC); cycle and retired-instruction counters are included. It sits between the IFU memory port and the IDU/EXU datapath.

Parameters:
XLEN, 64, width of PC and next-PC (32 or 64)
RESET_PC, 64'h8000_0000, PC value after reset (truncated to XLEN)
CNT_W, 64, width of cycle_cnt and instret
MAX_WAIT, 255, maximum FETCH cycles without ifu_valid before timeout halt (1..2^16-1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
run  in  1  1 = free-running; 0 = pause at next instruction boundary
ifu_req  out  1  fetch request, held high in FETCH
ifu_addr  out  XLEN  fetch address (= pc)
ifu_valid  in  1  fetch response valid
ifu_inst  in  32  fetched instruction
ifu_err  in  1  fetch access fault, qualified by ifu_valid
inst  out  32  latched current instruction, fed to IDU
pc  out  XLEN  PC of current instruction
exe_start  out  1  one-cycle pulse on EXEC entry
exe_done  in  1  EXU result ready
exe_next_pc  in  XLEN  next PC from EXU, sampled with exe_done
wb_en  out  1  one-cycle register-file write strobe
halted  out  1  sticky halt flag
halt_code  out  3  0 none, 1 ebreak, 2 fetch fault, 3 fetch timeout, 4 misaligned next PC
halt_pulse  out  1  one-cycle pulse on the cycle halted rises (drives finish_sim DPI)
cycle_cnt  out  CNT_W  cycles spent in FETCH/EXEC/WB
instret  out  CNT_W  retired instructions

Behaviour:
- Reset (rst=1 at posedge, any state):
  - state=IDLE, pc=RESET_PC, inst=0.
  - All counters 0.
  - halted, halt_code, halt_pulse, ifu_req, exe_start and wb_en all 0.
  - Reset mid-fetch or mid-exec abandons the operation; a late ifu_valid or exe_done is ignored.
- States: IDLE, FETCH, EXEC, WB, HALT.
- IDLE:
  - run=1 -> FETCH next cycle; the wait counter clears.
  - run=0 -> stay in IDLE.
- FETCH:
  - ifu_req=1; ifu_addr=pc. The wait counter increments each cycle ifu_valid=0.
  - ifu_valid=1, ifu_err=1 -> HALT, code 2.
  - ifu_valid=1, ifu_err=0:
    - inst<=ifu_inst.
    - If ifu_inst==32'h0010_0073 (ebreak) -> HALT, code 1, instret+1.
    - Otherwise -> EXEC.
  - Wait counter reaches MAX_WAIT while ifu_valid=0 -> HALT, code 3.
  - ifu_valid on the same cycle as the timeout wins; it is serviced normally.
- EXEC:
  - exe_start=1 on the first EXEC cycle only.
  - exe_done is accepted from that same cycle onward (zero-wait EXU allowed).
  - On exe_done:
    - If exe_next_pc[1:0]!=0 -> HALT, code 4, no writeback.
    - Otherwise capture exe_next_pc -> WB.
- WB (exactly 1 cycle):
  - wb_en=1; pc<=captured next PC; instret+1.
  - Next state: FETCH if run=1, else IDLE.
  - run is only sampled at WB/IDLE; deasserting run in FETCH/EXEC has no effect until the boundary.
- HALT:
  - Absorbing until rst. halted=1 and halt_code holds its value.
  - ifu_req, exe_start and wb_en stay 0; pc and inst hold their values.
  - halt_pulse=1 only on the first HALT cycle.
- Counters:
  - cycle_cnt increments every cycle the state is FETCH, EXEC or WB.
  - Both counters wrap modulo 2^CNT_W with no saturation.
- Output timing:
  - All outputs are registered or decoded from state.
  - There is no combinational path from ifu_valid or exe_done to any output.

Test Plan:
1. Reset then run=1; the memory model returns addi (0x00500093) with 0-cycle latency, and EXU returns done immediately with next_pc=pc+4 -> ifu_addr=0x80000000; wb_en pulses on cycle 4; pc=0x80000004; instret=1; cycle_cnt=3.
2. Ebreak as the 3rd instruction -> halted=1, halt_code=1, halt_pulse high for exactly 1 cycle, instret=3; no further ifu_req for 20 cycles.
3. Memory model never responds, MAX_WAIT=4 -> HALT code 3 after 4 FETCH cycles; ifu_valid on the 4th cycle instead -> normal EXEC entry.
4. ifu_valid=1 with ifu_err=1 at pc 0x80000008 -> halt_code=2, pc stays 0x80000008, wb_en never asserted.
5. EXU returns next_pc=0x80000102 -> halt_code=4, instret unchanged, no wb_en.
6. Drop run during EXEC, then assert rst during a later 3-cycle fetch wait -> core finishes the instruction and parks in IDLE with cycle_cnt frozen; after reset, pc=0x80000000 and all outputs are 0.

Source files
------------

// File: rtl/npc_mc_ctrl_if.sv
// npc_mc_ctrl_if: IFU fetch port and IDU/EXU handshake bundle of the NPC sequencer
interface npc_mc_ctrl_if #(parameter int XLEN = 64);
  logic ifu_req;
  logic [XLEN-1:0] ifu_addr;
  logic ifu_valid;
  logic [31:0] ifu_inst;
  logic ifu_err;
  logic [31:0] inst;
  logic [XLEN-1:0] pc;
  logic exe_start;
  logic exe_done;
  logic [XLEN-1:0] exe_next_pc;
  logic wb_en;
  modport master (
    output ifu_req, ifu_addr, inst, pc, exe_start, wb_en,
    input ifu_valid, ifu_inst, ifu_err, exe_done, exe_next_pc
  );
  modport slave (
    input ifu_req, ifu_addr, inst, pc, exe_start, wb_en,
    output ifu_valid, ifu_inst, ifu_err, exe_done, exe_next_pc
  );
endinterface

// File: rtl/npc_mc_ctrl.sv
// npc_mc_ctrl: multi-cycle FETCH/EXEC/WB sequencer with sticky halt cause and perf counters
module npc_mc_ctrl #(
  parameter int XLEN = 64,
  parameter logic [63:0] RESET_PC = 64'h8000_0000,
  parameter int CNT_W = 64,
  parameter int MAX_WAIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_run,
  npc_mc_ctrl_if.master bus,
  output logic o_halted,
  output logic [2:0] o_halt_code,
  output logic o_halt_pulse,
  output logic [CNT_W-1:0] o_cycle_cnt,
  output logic [CNT_W-1:0] o_instret
);
  typedef enum logic [2:0] {IDLE, FETCH, EXEC, WB, HALT} state_t;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [15:0] WAIT_LAST = 16'(MAX_WAIT - 1);
  state_t r_state, w_next;
  logic [XLEN-1:0] r_pc, r_npc;
  logic [31:0] r_inst;
  logic [15:0] r_wait;
  logic [2:0] r_code, w_code;
  logic r_exe_start, r_halt_pulse;
  logic [CNT_W-1:0] r_cycle, r_instret;
  logic w_fetch_ok, w_ebreak, w_misalign;
  assign w_fetch_ok = r_state == FETCH && bus.ifu_valid && !bus.ifu_err;
  assign w_ebreak = w_fetch_ok && bus.ifu_inst == EBREAK;
  assign w_misalign = bus.exe_next_pc[1:0] != 2'b00;
  // next state, plus the cause to latch when this cycle enters HALT
  always_comb begin
    w_next = r_state;
    w_code = 3'd0;
    case (r_state)
      IDLE: w_next = i_run ? FETCH : IDLE;
      FETCH:
        if (bus.ifu_valid) begin
          w_next = bus.ifu_err || w_ebreak ? HALT : EXEC;
          w_code = bus.ifu_err ? 3'd2 : w_ebreak ? 3'd1 : 3'd0;
        end else if (r_wait == WAIT_LAST) begin
          w_next = HALT;
          w_code = 3'd3;
        end
      EXEC:
        if (bus.exe_done) begin
          w_next = w_misalign ? HALT : WB;
          w_code = w_misalign ? 3'd4 : 3'd0;
        end
      WB: w_next = i_run ? FETCH : IDLE;
      default: w_next = HALT;
    endcase
  end
  // state register
  always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;
  // datapath, halt cause, entry strobes and counters; wait counter restarts on every FETCH entry
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= XLEN'(RESET_PC);
      r_npc <= '0;
      r_inst <= '0;
      r_wait <= '0;
      r_code <= '0;
      r_exe_start <= 1'b0;
      r_halt_pulse <= 1'b0;
      r_cycle <= '0;
      r_instret <= '0;
    end else begin
      r_wait <= r_state == FETCH ? r_wait + 16'd1 : 16'd0;
      r_exe_start <= r_state == FETCH && w_next == EXEC;
      r_halt_pulse <= r_state != HALT && w_next == HALT;
      if (r_state != HALT && w_next == HALT) r_code <= w_code;
      if (w_fetch_ok) r_inst <= bus.ifu_inst;
      if (r_state == EXEC && bus.exe_done) r_npc <= bus.exe_next_pc;
      if (r_state == WB) r_pc <= r_npc;
      if (r_state inside {FETCH, EXEC, WB}) r_cycle <= r_cycle + CNT_W'(1);
      if (r_state == WB || w_ebreak) r_instret <= r_instret + CNT_W'(1);
    end
  end
  assign bus.ifu_req = r_state == FETCH;
  assign bus.ifu_addr = r_pc;
  assign bus.pc = r_pc;
  assign bus.inst = r_inst;
  assign bus.exe_start = r_exe_start;
  assign bus.wb_en = r_state == WB;
  assign o_halted = r_state == HALT;
  assign o_halt_code = r_code;
  assign o_halt_pulse = r_halt_pulse;
  assign o_cycle_cnt = r_cycle;
  assign o_instret = r_instret;
endmodule

// File: tb/tb_npc_mc_ctrl.sv
// tb_npc_mc_ctrl: scoreboarded random/directed bench for the multi-cycle sequencer
module tb_npc_mc_ctrl;
  localparam int XLEN = 64;
  localparam int MW = 4;
  localparam logic [63:0] RPC = 64'h8000_0000;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] ADDI = 32'h0050_0093;
  typedef struct {
    bit halt;
    logic [2:0] code;
    logic [63:0] pc;
    logic [31:0] inst;
    logic [63:0] ret;
    logic [63:0] cyc;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, run = 1'b0;
  logic halted, halt_pulse;
  logic [2:0] halt_code;
  logic [63:0] cycle_cnt, instret;
  npc_mc_ctrl_if #(.XLEN(XLEN)) bus ();
  npc_mc_ctrl #(.XLEN(XLEN), .RESET_PC(RPC), .CNT_W(64), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst), .i_run(run), .bus(bus),
    .o_halted(halted), .o_halt_code(halt_code), .o_halt_pulse(halt_pulse),
    .o_cycle_cnt(cycle_cnt), .o_instret(instret)
  );
  always #5 clk = ~clk;
  exp_t q[$];
  exp_t e;
  int vectors = 0, errors = 0;
  logic prev_halted = 1'b0;
  logic [63:0] m_pc, m_ret, m_cyc;
  logic [31:0] m_inst;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    vectors++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask
  // monitor: every wb_en or halt_pulse must match the oldest expected event
  always @(negedge clk) begin
    if (!rst && (bus.wb_en || halt_pulse)) begin
      if (q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected_event: wb_en=%b halt_pulse=%b with empty scoreboard", bus.wb_en, halt_pulse);
      end else begin
        e = q.pop_front();
        chk("event_is_halt", {63'd0, halt_pulse}, {63'd0, e.halt});
        chk("event_wb_en", {63'd0, bus.wb_en}, {63'd0, !e.halt});
        chk("event_halt_code", {61'd0, halt_code}, {61'd0, e.code});
        chk("event_pc", bus.pc, e.pc);
        chk("event_inst", {32'd0, bus.inst}, {32'd0, e.inst});
        chk("event_instret", instret, e.ret);
        chk("event_cycle_cnt", cycle_cnt, e.cyc);
        if (halt_pulse) chk("halt_pulse_first_cycle", {63'd0, prev_halted}, 64'd0);
      end
    end
    prev_halted = halted;
  end
  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  task automatic do_reset();
    rst = 1'b1;
    bus.ifu_valid = 1'b0;
    bus.ifu_err = 1'b0;
    bus.exe_done = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_pc = RPC;
    m_ret = 0;
    m_cyc = 0;
    m_inst = 0;
    chk("rst_pc", bus.pc, RPC);
    chk("rst_inst", {32'd0, bus.inst}, 64'd0);
    chk("rst_ifu_req", {63'd0, bus.ifu_req}, 64'd0);
    chk("rst_exe_start", {63'd0, bus.exe_start}, 64'd0);
    chk("rst_wb_en", {63'd0, bus.wb_en}, 64'd0);
    chk("rst_halted", {63'd0, halted}, 64'd0);
    chk("rst_halt_code", {61'd0, halt_code}, 64'd0);
    chk("rst_halt_pulse", {63'd0, halt_pulse}, 64'd0);
    chk("rst_cycle_cnt", cycle_cnt, 64'd0);
    chk("rst_instret", instret, 64'd0);
  endtask
  task automatic wait_req(output bit ok);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      if (bus.ifu_req) begin
        ok = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      vectors++;
      errors++;
      $display("FAIL wait_ifu_req: no fetch request within 50 cycles");
    end
  endtask
  task automatic check_halt(input logic [2:0] code);
    int busy = 0;
    chk("halted_set", {63'd0, halted}, 64'd1);
    repeat (20) begin
      @(posedge clk);
      #1;
      busy += int'(bus.ifu_req) + int'(bus.wb_en) + int'(bus.exe_start) + int'(halt_pulse);
    end
    chk("halt_quiet_strobes", busy, 0);
    chk("halt_sticky", {63'd0, halted}, 64'd1);
    chk("halt_code_held", {61'd0, halt_code}, {61'd0, code});
    chk("halt_pc_held", bus.pc, m_pc);
    chk("halt_inst_held", {32'd0, bus.inst}, {32'd0, m_inst});
    chk("halt_cycle_frozen", cycle_cnt, m_cyc);
    chk("halt_instret_frozen", instret, m_ret);
  endtask
  // one instruction: L idle fetch cycles (L>=MW times out), D extra EXEC cycles
  task automatic step(input int L, input int D, input logic [31:0] ins, input bit err,
                      input logic [63:0] npc, input bit drop_run, output bit hlt);
    bit ok;
    logic [2:0] code;
    hlt = 1;
    code = 3'd0;
    if (L >= MW) begin
      m_cyc += 64'(MW);
      code = 3'd3;
    end else if (err) begin
      m_cyc += 64'(L + 1);
      code = 3'd2;
    end else if (ins == EBREAK) begin
      m_cyc += 64'(L + 1);
      m_ret += 1;
      m_inst = ins;
      code = 3'd1;
    end else if (npc[1:0] != 2'b00) begin
      m_cyc += 64'(L + D + 2);
      m_inst = ins;
      code = 3'd4;
    end else begin
      m_inst = ins;
      q.push_back('{1'b0, 3'd0, m_pc, ins, m_ret, m_cyc + 64'(L + D + 2)});
    end
    if (code != 3'd0) q.push_back('{1'b1, code, m_pc, m_inst, m_ret, m_cyc});
    wait_req(ok);
    if (!ok) return;
    chk("ifu_addr", bus.ifu_addr, m_pc);
    repeat (L < MW ? L : MW) begin
      @(posedge clk);
      #1;
    end
    if (L < MW) begin
      bus.ifu_valid = 1'b1;
      bus.ifu_err = err;
      bus.ifu_inst = ins;
      @(posedge clk);
      #1;
      bus.ifu_valid = 1'b0;
      bus.ifu_err = 1'b0;
      bus.ifu_inst = $urandom;
      if (!err && ins != EBREAK) begin
        chk("exe_start", {63'd0, bus.exe_start}, 64'd1);
        if (drop_run) run = 1'b0;
        repeat (D) begin
          @(posedge clk);
          #1;
          chk("exe_start_once", {63'd0, bus.exe_start}, 64'd0);
        end
        bus.exe_done = 1'b1;
        bus.exe_next_pc = npc;
        @(posedge clk);
        #1;
        bus.exe_done = 1'b0;
        bus.exe_next_pc = {$urandom, $urandom};
        if (npc[1:0] == 2'b00) begin
          @(posedge clk);
          #1;
          m_pc = npc;
          m_ret += 1;
          m_cyc += 64'(L + D + 3);
          chk("wb_pc", bus.pc, m_pc);
          chk("wb_instret", instret, m_ret);
          chk("wb_cycle_cnt", cycle_cnt, m_cyc);
          hlt = 0;
          return;
        end
      end
    end
    check_halt(code);
  endtask
  initial begin
    bit h, ok;
    int r, L;
    logic [31:0] ins;
    logic [63:0] npc;
    bus.ifu_valid = 1'b0;
    bus.ifu_err = 1'b0;
    bus.ifu_inst = '0;
    bus.exe_done = 1'b0;
    bus.exe_next_pc = '0;
    run = 1'b1;
    do_reset();
    step(0, 0, ADDI, 0, RPC + 4, 0, h);
    step(1, 2, ADDI, 0, RPC + 8, 0, h);
    step(2, 0, EBREAK, 0, 64'd0, 0, h);
    chk("ebreak_halts", {63'd0, h}, 64'd1);
    do_reset();
    step(MW, 0, ADDI, 0, RPC + 4, 0, h);
    do_reset();
    step(MW - 1, 0, ADDI, 0, RPC + 4, 0, h);
    chk("valid_on_last_wait_cycle_serviced", {63'd0, h}, 64'd0);
    do_reset();
    step(0, 0, ADDI, 0, RPC + 4, 0, h);
    step(0, 1, ADDI, 0, RPC + 8, 0, h);
    step(1, 0, ADDI, 1, 64'd0, 0, h);
    do_reset();
    step(0, 1, ADDI, 0, 64'h8000_0102, 0, h);
    do_reset();
    step(0, 1, ADDI, 0, RPC + 4, 1, h);
    repeat (5) @(posedge clk);
    #1;
    chk("paused_no_req", {63'd0, bus.ifu_req}, 64'd0);
    chk("paused_cycle_frozen", cycle_cnt, m_cyc);
    chk("paused_pc", bus.pc, m_pc);
    run = 1'b1;
    wait_req(ok);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    bus.ifu_valid = 1'b1;
    bus.ifu_inst = ADDI;
    bus.exe_done = 1'b1;
    @(posedge clk);
    #1;
    do_reset();
    chk("scoreboard_drained_directed", q.size(), 0);
    for (int ep = 0; ep < 20; ep++) begin
      do_reset();
      for (int k = 0; k < 15; k++) begin
        r = $urandom_range(0, 99);
        L = r < 8 ? MW : $urandom_range(0, MW - 1);
        ins = $urandom;
        if (ins == EBREAK) ins = ins ^ 32'd1;
        r = $urandom_range(0, 99);
        if (r < 5) ins = EBREAK;
        npc = m_pc + {52'd0, 10'($urandom_range(0, 255)), 2'b00};
        if ($urandom_range(0, 99) < 5) npc = npc | 64'($urandom_range(1, 3));
        step(L, $urandom_range(0, 3), ins, $urandom_range(0, 99) < 5, npc, 0, h);
        if (h) break;
      end
      chk("scoreboard_drained", q.size(), 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
